// File: rtl/level_pkg.sv
// Shared types and constants for the level sequencer.
// Optional lives support is enabled by defining SEQ_LIVES_EN.
package level_pkg;

  localparam int unsigned MAX_LEVEL_DEF   = 8;
  localparam int unsigned SHOW_SECS_DEF   = 3;
  localparam int unsigned ANSWER_SECS_DEF = 10;
  localparam int unsigned LVL_W_DEF       = 4;
  localparam int unsigned SEC_W_DEF       = 4;
  localparam int unsigned LIVES_W         = 2;
  localparam int unsigned LIVES_INIT      = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRELIM,
    ST_SHOW,
    ST_ANSWER,
    ST_JUDGE_OK,
    ST_WIN,
    ST_OVER
  } state_e;

  // Window/status flags that are a pure function of the sequencer state
  typedef struct packed {
    logic prelim;
    logic show;
    logic accept;
    logic game_over;
    logic win;
  } flags_t;

  // Decode a state into its externally visible flags
  function automatic flags_t state_flags(input state_e s);
    flags_t f;
    f           = '0;
    f.prelim    = (s == ST_PRELIM);
    f.show      = (s == ST_SHOW);
    f.accept    = (s == ST_ANSWER);
    f.game_over = (s == ST_OVER);
    f.win       = (s == ST_WIN);
    return f;
  endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Player-side bus of the level sequencer.
// The lives signal exists only when SEQ_LIVES_EN is defined.
interface level_sequencer_if
  import level_pkg::*;
#(
  parameter int unsigned LVL_W = LVL_W_DEF,
  parameter int unsigned SEC_W = SEC_W_DEF
);

  logic             start;
  logic             answerValid;
  logic             answerCorrect;
  logic             prelimSig;
  logic             showSymbols;
  logic             acceptAnswer;
  logic [LVL_W-1:0] level;
  logic [SEC_W-1:0] secondsLeft;
  logic             gameOver;
  logic             win;
`ifdef SEQ_LIVES_EN
  logic [LIVES_W-1:0] lives;

  modport master (
    output start, answerValid, answerCorrect,
    input  prelimSig, showSymbols, acceptAnswer, level, secondsLeft, gameOver, win, lives
  );

  modport slave (
    input  start, answerValid, answerCorrect,
    output prelimSig, showSymbols, acceptAnswer, level, secondsLeft, gameOver, win, lives
  );
`else
  modport master (
    output start, answerValid, answerCorrect,
    input  prelimSig, showSymbols, acceptAnswer, level, secondsLeft, gameOver, win
  );

  modport slave (
    input  start, answerValid, answerCorrect,
    output prelimSig, showSymbols, acceptAnswer, level, secondsLeft, gameOver, win
  );
`endif

endinterface

// File: rtl/tick_sync.sv
// Brings the raw 1 Hz square wave into the system clock domain and
// emits a one-cycle pulse on each of its rising edges.
module tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick_c
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-flop synchronizer followed by an edge-history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick_c = sync2_q & ~prev_q;

endmodule

// File: rtl/level_sequencer.sv
// Round controller for the symbol-counting game: prelim pulse, display
// window, answer window, judge, then next level or game end.
// Define SEQ_LIVES_EN to give the player three attempts per game.
module level_sequencer
  import level_pkg::*;
#(
  parameter int unsigned MAX_LEVEL   = MAX_LEVEL_DEF,
  parameter int unsigned SHOW_SECS   = SHOW_SECS_DEF,
  parameter int unsigned ANSWER_SECS = ANSWER_SECS_DEF,
  parameter int unsigned LVL_W       = LVL_W_DEF,
  parameter int unsigned SEC_W       = SEC_W_DEF
) (
  input logic              Clk100M,
  input logic              Rst_n,
  input logic              Clk1Hz,
  level_sequencer_if.slave bus
);

  logic             sec_tick_c;
  state_e           state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  flags_t           flags_q, flags_d;
  logic             start_prev_q;
  logic             start_rise;
  logic             fail;
`ifdef SEQ_LIVES_EN
  logic [LIVES_W-1:0] lives_q, lives_d;
`endif

  tick_sync u_tick_sync (
    .clk      (Clk100M),
    .rst_n    (Rst_n),
    .async_in (Clk1Hz),
    .tick_c   (sec_tick_c)
  );

  assign start_rise = bus.start & ~start_prev_q;

  // Next-state, level, countdown and flag computation
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    secs_d  = secs_q;
    fail    = 1'b0;
`ifdef SEQ_LIVES_EN
    lives_d = lives_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_PRELIM;
          level_d = LVL_W'(1);
          secs_d  = SEC_W'(SHOW_SECS);
        end
      end

      ST_PRELIM: state_d = ST_SHOW;

      ST_SHOW: begin
        if (sec_tick_c) begin
          if (secs_q == SEC_W'(1)) begin
            state_d = ST_ANSWER;
            secs_d  = SEC_W'(ANSWER_SECS);
          end else if (secs_q != '0) begin
            secs_d = secs_q - SEC_W'(1);
          end
        end
      end

      ST_ANSWER: begin
        // A submitted answer takes precedence over a coincident timeout tick
        if (bus.answerValid) begin
          if (bus.answerCorrect) state_d = ST_JUDGE_OK;
          else                   fail    = 1'b1;
        end else if (sec_tick_c) begin
          if (secs_q == SEC_W'(1))  fail   = 1'b1;
          else if (secs_q != '0)    secs_d = secs_q - SEC_W'(1);
        end
      end

      ST_JUDGE_OK: begin
        if (level_q >= LVL_W'(MAX_LEVEL)) begin
          state_d = ST_WIN;
          secs_d  = '0;
        end else begin
          state_d = ST_PRELIM;
          level_d = level_q + LVL_W'(1);
          secs_d  = SEC_W'(SHOW_SECS);
        end
      end

      ST_WIN, ST_OVER: begin
        secs_d = '0;
        if (start_rise) begin
          state_d = ST_PRELIM;
          level_d = LVL_W'(1);
          secs_d  = SEC_W'(SHOW_SECS);
`ifdef SEQ_LIVES_EN
          lives_d = LIVES_W'(LIVES_INIT);
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Wrong answer or timeout: retry the same level while lives remain
    if (fail) begin
`ifdef SEQ_LIVES_EN
      if (lives_q > LIVES_W'(1)) begin
        lives_d = lives_q - LIVES_W'(1);
        state_d = ST_PRELIM;
        secs_d  = SEC_W'(SHOW_SECS);
      end else begin
        lives_d = '0;
        state_d = ST_OVER;
        secs_d  = '0;
      end
`else
      state_d = ST_OVER;
      secs_d  = '0;
`endif
    end

    flags_d = state_flags(state_d);
  end

  // Sequencer registers; reset aborts any round without a pulse
  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= ST_IDLE;
      level_q      <= LVL_W'(1);
      secs_q       <= '0;
      flags_q      <= '0;
      start_prev_q <= 1'b0;
`ifdef SEQ_LIVES_EN
      lives_q      <= LIVES_W'(LIVES_INIT);
`endif
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      secs_q       <= secs_d;
      flags_q      <= flags_d;
      start_prev_q <= bus.start;
`ifdef SEQ_LIVES_EN
      lives_q      <= lives_d;
`endif
    end
  end

  assign bus.prelimSig    = flags_q.prelim;
  assign bus.showSymbols  = flags_q.show;
  assign bus.acceptAnswer = flags_q.accept;
  assign bus.gameOver     = flags_q.game_over;
  assign bus.win          = flags_q.win;
  assign bus.level        = level_q;
  assign bus.secondsLeft  = secs_q;
`ifdef SEQ_LIVES_EN
  assign bus.lives        = lives_q;
`endif

endmodule
